// File: rtl/idi_pkg.sv
// Shared definitions for the IDI request path.
//   IDI_ADDR_W / IDI_DATA_W : default address / data widths of the sink interface.
//   idi_req_t               : one queued request {is_write, addr, wdata}.
package idi_pkg;
    localparam int unsigned IDI_ADDR_W = 64;
    localparam int unsigned IDI_DATA_W = 32;

    typedef struct packed {
        logic                  is_write;
        logic [IDI_ADDR_W-1:0] addr;
        logic [IDI_DATA_W-1:0] wdata;
    } idi_req_t;
endpackage

// File: rtl/idi_sync_fifo.sv
// Generic synchronous FIFO storage: DEPTH entries of type T with read/write
// pointers and an occupancy counter.
//   clk, rst   : rising-edge clock, synchronous active-high reset (control only)
//   push       : write push_data at the tail (caller never pushes when full)
//   push_data  : entry to store
//   pop        : drop the head entry (caller never pops when empty)
//   head       : entry at the read pointer
//   occupancy  : number of stored entries, 0..DEPTH
module idi_sync_fifo
    import idi_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = idi_req_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is data only; stale contents are never observable because
    // occupancy gates every use of the head.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head      = mem_q[rd_ptr_q];
    assign occupancy = occ_q;
endmodule

// File: rtl/idi_req_fifo.sv
// Request buffer in front of idi_sink. Queues read/write requests in order,
// presents the head to the sink and returns read data through a one-entry
// response register. A read head is held back while that register is full.
// Optional statistics outputs are built when IDI_REQ_FIFO_STATS_EN is defined.
//   up_*        : upstream request channel (valid/ready)
//   snk_*       : sink channel, driven from the FIFO head
//   rsp_*       : read response channel (valid/ready)
//   occupancy   : current FIFO entry count
//   stat_*      : completed write/read counts and occupancy high-water mark
module idi_req_fifo
    import idi_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = IDI_ADDR_W,
    parameter int unsigned DATA_W = IDI_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic                   up_is_write,
    input  logic [ADDR_W-1:0]      up_addr,
    input  logic [DATA_W-1:0]      up_wdata,
    output logic                   snk_valid,
    input  logic                   snk_ready,
    output logic                   snk_is_write,
    output logic [ADDR_W-1:0]      snk_addr,
    output logic [DATA_W-1:0]      snk_wdata,
    input  logic [DATA_W-1:0]      snk_rdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef IDI_REQ_FIFO_STATS_EN
    ,
    output logic [31:0]            stat_wr_cnt,
    output logic [31:0]            stat_rd_cnt,
    output logic [$clog2(DEPTH):0] stat_max_occ
`endif
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t        push_req;
    req_t        head;
    logic        push;
    logic        pop;
    logic        capture;
    logic        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    assign push_req = {up_is_write, up_addr, up_wdata};

    // Ready depends only on registered occupancy, so a full FIFO refuses a
    // push even in a cycle where the sink pops.
    assign up_ready = !rst && (occupancy != CNT_W'(DEPTH));
    assign push     = up_valid && up_ready;

    idi_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head),
        .occupancy (occupancy)
    );

    // A read head may only issue if its response has somewhere to land:
    // the slot is empty or is being drained this same cycle.
    assign snk_valid    = (occupancy != '0) &&
                          !(!head.is_write && rsp_valid_q && !rsp_ready);
    assign snk_is_write = head.is_write;
    assign snk_addr     = head.addr;
    assign snk_wdata    = head.wdata;

    assign pop     = snk_valid && snk_ready;
    assign capture = pop && !head.is_write;

    // A capture wins over a drain, keeping the slot full with new data.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = snk_rdata;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef IDI_REQ_FIFO_STATS_EN
    logic [31:0]      stat_wr_cnt_q, stat_wr_cnt_d;
    logic [31:0]      stat_rd_cnt_q, stat_rd_cnt_d;
    logic [CNT_W-1:0] stat_max_occ_q, stat_max_occ_d;

    always_comb begin
        stat_wr_cnt_d  = stat_wr_cnt_q;
        stat_rd_cnt_d  = stat_rd_cnt_q;
        stat_max_occ_d = stat_max_occ_q;
        if (pop &&  head.is_write) stat_wr_cnt_d = stat_wr_cnt_q + 32'd1;
        if (pop && !head.is_write) stat_rd_cnt_d = stat_rd_cnt_q + 32'd1;
        if (occupancy > stat_max_occ_q) stat_max_occ_d = occupancy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wr_cnt_q  <= '0;
            stat_rd_cnt_q  <= '0;
            stat_max_occ_q <= '0;
        end else begin
            stat_wr_cnt_q  <= stat_wr_cnt_d;
            stat_rd_cnt_q  <= stat_rd_cnt_d;
            stat_max_occ_q <= stat_max_occ_d;
        end
    end

    assign stat_wr_cnt  = stat_wr_cnt_q;
    assign stat_rd_cnt  = stat_rd_cnt_q;
    assign stat_max_occ = stat_max_occ_q;
`endif
endmodule
